// File: rtl/vdm_pkg.sv
// Shared types and helpers for the vector data memory.
package vdm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Number of beats needed to service every lane, PORTS lanes at a time.
  function automatic int beat_count(input int vec_size, input int ports);
    return (vec_size + ports - 1) / ports;
  endfunction

  // Number of byte-offset bits dropped from a byte address to get a word index.
  function automatic int off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/vdm_lane_addr_gen.sv
// Per-lane word index and out-of-range flag from base byte address and
// signed word stride. Purely combinational.
module vdm_lane_addr_gen
  import vdm_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 65536,
  parameter int VEC_SIZE  = 4,
  parameter int STRIDE_W  = 8,
  parameter int MEM_AW    = 16
) (
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [STRIDE_W-1:0]        stride,
  output logic [VEC_SIZE*MEM_AW-1:0] lane_idx,
  output logic [VEC_SIZE-1:0]        lane_err
);

  localparam int OFF = off_bits(DATA_W);

  logic [ADDR_W-1:0] base_word;
  logic [ADDR_W-1:0] stride_ext;

  assign base_word  = base_addr >> OFF;
  assign stride_ext = ADDR_W'($signed(stride));

  genvar gi;
  generate
    for (gi = 0; gi < VEC_SIZE; gi++) begin : gen_lane
      logic [ADDR_W-1:0] idx;
      // Index arithmetic wraps modulo 2^ADDR_W; the range check sees the full value.
      assign idx = base_word + ADDR_W'(gi) * stride_ext;
      assign lane_err[gi] = (idx >= ADDR_W'(MEM_DEPTH));
      assign lane_idx[gi*MEM_AW +: MEM_AW] = idx[MEM_AW-1:0];
    end
  endgenerate

endmodule

// File: rtl/vector_data_memory.sv
// Vector data memory: whole-vector masked/strided loads and stores over a
// valid/ready handshake, PORTS lanes per beat, per-lane range errors.
module vector_data_memory
  import vdm_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 65536,
  parameter int VEC_SIZE  = 4,
  parameter int PORTS     = 2,
  parameter int STRIDE_W  = 8,
  parameter     INIT_FILE = "RAM.txt"
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [STRIDE_W-1:0]        req_stride,
  input  logic [VEC_SIZE-1:0]        req_mask,
  input  logic [VEC_SIZE*DATA_W-1:0] req_wdata,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic                       resp_write,
  output logic [VEC_SIZE*DATA_W-1:0] resp_rdata,
  output logic [VEC_SIZE-1:0]        resp_err
);

  localparam int NUM_BEATS = beat_count(VEC_SIZE, PORTS);
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int MEM_AW    = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  state_t                      state_q, state_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic                        write_q, write_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [STRIDE_W-1:0]         stride_q, stride_d;
  logic [VEC_SIZE-1:0]         mask_q, mask_d;
  logic [VEC_SIZE*DATA_W-1:0]  wdata_q, wdata_d;

  logic                        accept;
  logic [VEC_SIZE*MEM_AW-1:0]  lane_idx;
  logic [VEC_SIZE-1:0]         lane_err;
  logic [VEC_SIZE-1:0]         lane_act;
  logic [VEC_SIZE-1:0]         lane_ok;
  logic [VEC_SIZE-1:0]         lane_we;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_write = write_q;
  assign accept     = req_valid && (state_q == IDLE);

  vdm_lane_addr_gen #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH),
    .VEC_SIZE (VEC_SIZE),
    .STRIDE_W (STRIDE_W),
    .MEM_AW   (MEM_AW)
  ) u_addr_gen (
    .base_addr(addr_q),
    .stride   (stride_q),
    .lane_idx (lane_idx),
    .lane_err (lane_err)
  );

  // Next-state, beat counter and request latch.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    write_d  = write_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    mask_d   = mask_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = BUSY;
          beat_d   = '0;
          write_d  = req_write;
          addr_d   = req_addr;
          stride_d = req_stride;
          mask_d   = req_mask;
          wdata_d  = req_wdata;
        end
      end
      BUSY: begin
        if (beat_q == BEAT_W'(NUM_BEATS - 1)) begin
          state_d = RESP;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      stride_q <= '0;
      mask_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      mask_q   <= mask_d;
      wdata_q  <= wdata_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < VEC_SIZE; gi++) begin : gen_lane
      localparam int LANE_BEAT = gi / PORTS;
      logic [DATA_W-1:0] rdata_q;
      logic              err_q;

      assign lane_act[gi] = (state_q == BUSY) && (beat_q == BEAT_W'(LANE_BEAT));
      assign lane_ok[gi]  = mask_q[gi] && !lane_err[gi];
      assign lane_we[gi]  = lane_act[gi] && lane_ok[gi] && write_q;

      // Response buffer slice: cleared on accept, filled during this lane's beat.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end else if (accept) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end else if (lane_act[gi]) begin
          err_q   <= lane_err[gi];
          rdata_q <= (!write_q && lane_ok[gi]) ? mem[lane_idx[gi*MEM_AW +: MEM_AW]] : '0;
        end
      end

      assign resp_rdata[gi*DATA_W +: DATA_W] = rdata_q;
      assign resp_err[gi] = err_q;
    end
  endgenerate

  // RAM write port: later lanes overwrite earlier ones, so the highest lane wins a collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < VEC_SIZE; i++) begin
      if (lane_we[i]) mem[lane_idx[i*MEM_AW +: MEM_AW]] <= wdata_q[i*DATA_W +: DATA_W];
    end
  end

endmodule
